// File: rtl/frame_sequencer.sv
// frame_sequencer: launches test-pattern frames on the AXI-Stream sender.
// It issues one-cycle GO pulses, follows the sender RUN handshake, inserts a
// programmable idle gap, and runs a fixed count or continuously until STOP.
// Optional feature: define SEQ_TIMEOUT_EN to enable the GO-to-RUN watchdog
// (sticky ERR, abort to IDLE after TIMEOUT_CYC cycles in WAIT_RUN).
module frame_sequencer #(
  parameter int CNT_W       = 16,
  parameter int GAP_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             START,
  input  logic             STOP,
  input  logic             CONTINUOUS,
  input  logic [CNT_W-1:0] NUM_FRAMES,
  input  logic [GAP_W-1:0] GAP_CYCLES,
  output logic             SENDER_GO,
  input  logic             SENDER_RUN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic             ERR
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_RUN = 3'd2;
  localparam logic [2:0] S_WAIT_END = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic             cont_q, cont_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             stop_pend_q, stop_pend_d;
  logic             go_q;
  logic             busy_q;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_inc_s;

`ifdef SEQ_TIMEOUT_EN
  localparam int            WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  // Parameter kept for interface compatibility; the watchdog is not built.
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYC);
`endif

  assign cnt_inc_s = cnt_q + CNT_ONE;

  // Next-state, counter and pulse decode for the frame sequencing FSM.
  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // STOP wins over a coincident START; STOP alone does nothing here.
        if (START && !STOP) begin
          if (CONTINUOUS || (NUM_FRAMES != {CNT_W{1'b0}})) begin
            cont_d  = CONTINUOUS;
            num_d   = NUM_FRAMES;
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_ISSUE;
`ifdef SEQ_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end else begin
            // Zero-length single run: finish immediately without a GO.
            cnt_d  = {CNT_W{1'b0}};
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (STOP) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
        state_d = S_WAIT_RUN;
`ifdef SEQ_TIMEOUT_EN
        wd_d    = {WD_W{1'b0}};
`endif
      end
      S_WAIT_RUN: begin
        if (STOP) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
        if (SENDER_RUN) begin
          state_d = S_WAIT_END;
        end else begin
`ifdef SEQ_TIMEOUT_EN
          if (wd_q == WD_LAST) begin
            // Sender never answered: abort without counting a frame.
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + WD_ONE;
          end
`else
          state_d = S_WAIT_RUN;
`endif
        end
      end
      S_WAIT_END: begin
        if (STOP) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
        if (!SENDER_RUN) begin
          cnt_d = cnt_inc_s;
          // A STOP arriving on the fall cycle also ends the run here.
          if (stop_pend_q || STOP || (!cont_q && (cnt_inc_s == num_q))) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (GAP_CYCLES == {GAP_W{1'b0}}) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_CYCLES - GAP_ONE;
          end
        end else begin
          state_d = S_WAIT_END;
        end
      end
      S_GAP: begin
        if (STOP) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gap_q == {GAP_W{1'b0}}) begin
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Pending stop is consumed whenever the sequencer returns to IDLE.
    if (state_d == S_IDLE) begin
      stop_pend_d = 1'b0;
    end else begin
      stop_pend_d = stop_pend_d;
    end
  end

  // State and registered outputs; reset forces everything idle immediately.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      cont_q      <= 1'b0;
      num_q       <= {CNT_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      gap_q       <= {GAP_W{1'b0}};
      stop_pend_q <= 1'b0;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      stop_pend_q <= stop_pend_d;
      go_q        <= (state_d == S_ISSUE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wd_q  <= {WD_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign SENDER_GO = go_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign FRAME_CNT = cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a simple stream-sender model.
module tb_frame_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [15:0] num_frames;
  logic [15:0] gap_cycles;
  logic        sender_go;
  logic        sender_run;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;

  // sender model controls
  bit sender_en = 1'b0;
  int run_len   = 10;

  // monitor state
  int          cyc = 0;
  int          go_cnt = 0;
  int          done_cnt = 0;
  int          last_go_cyc = 0;
  int          last_done_cyc = 0;
  int          fall_cyc = 0;
  bit          have_fall = 1'b0;
  int          last_gap = -1;
  int          step_bad = 0;
  logic        prev_run = 1'b0;
  logic [15:0] prev_fc = 16'd0;

  int go_base;
  int done_base;

  frame_sequencer #(
    .CNT_W(16),
    .GAP_W(16),
    .TIMEOUT_CYC(16)
  ) dut (
    .ACLK(aclk),
    .ARESETN(aresetn),
    .START(start),
    .STOP(stop),
    .CONTINUOUS(continuous),
    .NUM_FRAMES(num_frames),
    .GAP_CYCLES(gap_cycles),
    .SENDER_GO(sender_go),
    .SENDER_RUN(sender_run),
    .BUSY(busy),
    .DONE(done),
    .FRAME_CNT(frame_cnt),
    .ERR(err)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Sender: raises RUN in the GO cycle and holds it for run_len cycles.
  initial begin
    sender_run = 1'b0;
    forever begin
      @(negedge aclk);
      if (sender_en && sender_go) begin
        sender_run = 1'b1;
        repeat (run_len) @(negedge aclk);
        sender_run = 1'b0;
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      cyc++;
      if (prev_run && !sender_run) begin
        fall_cyc  = cyc;
        have_fall = 1'b1;
      end
      if (sender_go) begin
        go_cnt++;
        last_go_cyc = cyc;
        if (have_fall) last_gap = cyc - fall_cyc;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (frame_cnt != prev_fc && frame_cnt != prev_fc + 16'd1 && frame_cnt != 16'd0)
        step_bad++;
      prev_fc  = frame_cnt;
      prev_run = sender_run;
    end
  end

  task automatic pulse_start(input logic c, input logic [15:0] n, input logic [15:0] g);
    @(negedge aclk);
    start = 1'b1; continuous = c; num_frames = n; gap_cycles = g;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge aclk);
    stop = 1'b1;
    @(negedge aclk);
    stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i = 0;
    bit seen = 1'b0;
    while (!seen && i < budget) begin
      @(posedge aclk);
      #2;
      if (done) seen = 1'b1;
      i++;
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_go(input int n, input int budget, input string tag);
    int i = 0;
    while (go_cnt < n && i < budget) begin
      @(posedge aclk);
      #2;
      i++;
    end
    if (go_cnt < n) chk({tag, "_timeout"}, 32'(go_cnt), 32'(n));
  endtask

  task automatic wait_cnt(input logic [15:0] n, input int budget, input string tag);
    int i = 0;
    while (frame_cnt != n && i < budget) begin
      @(posedge aclk);
      #2;
      i++;
    end
    if (frame_cnt != n) chk({tag, "_timeout"}, 32'(frame_cnt), 32'(n));
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    num_frames = 16'd0; gap_cycles = 16'd0;
    repeat (3) @(negedge aclk);
    chk("rst_go",   32'(sender_go), 32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_done", 32'(done),      32'd0);
    chk("rst_cnt",  32'(frame_cnt), 32'd0);
    chk("rst_err",  32'(err),       32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // 1: single mode, 3 frames, gap 4
    sender_en = 1'b1; run_len = 10;
    go_base = go_cnt; done_base = done_cnt;
    pulse_start(1'b0, 16'd3, 16'd4);
    chk("t1_latency_go", 32'(sender_go), 32'd1);
    chk("t1_busy",       32'(busy),      32'd1);
    wait_done(200, "t1_done");
    chk("t1_go_count", 32'(go_cnt - go_base), 32'd3);
    chk("t1_cnt",      32'(frame_cnt),        32'd3);
    chk("t1_gap",      32'(last_gap),         32'd4);
    chk("t1_busy_end", 32'(busy),             32'd0);
    chk("t1_cnt_step", 32'(step_bad),         32'd0);
    repeat (10) @(negedge aclk);
    chk("t1_done_once", 32'(done_cnt - done_base), 32'd1);
    chk("t1_go_after",  32'(go_cnt - go_base),     32'd3);

    // 2: continuous, gap 0, STOP during frame 5
    go_base = go_cnt;
    pulse_start(1'b1, 16'd2, 16'd0);
    wait_go(go_base + 5, 200, "t2_go5");
    repeat (3) @(negedge aclk);
    chk("t2_run_high", 32'(sender_run), 32'd1);
    pulse_stop();
    wait_done(100, "t2_done");
    chk("t2_cnt",      32'(frame_cnt),        32'd5);
    chk("t2_go_count", 32'(go_cnt - go_base), 32'd5);
    chk("t2_gap0",     32'(last_gap),         32'd0);
    chk("t2_busy_end", 32'(busy),             32'd0);
    repeat (30) @(negedge aclk);
    chk("t2_no_6th_go", 32'(go_cnt - go_base), 32'd5);

    // 3: STOP in GAP after frame 2
    go_base = go_cnt;
    pulse_start(1'b0, 16'd10, 16'd8);
    wait_cnt(16'd2, 100, "t3_cnt2");
    pulse_stop();
    chk("t3_done", 32'(done),      32'd1);
    chk("t3_busy", 32'(busy),      32'd0);
    chk("t3_cnt",  32'(frame_cnt), 32'd2);
    repeat (30) @(negedge aclk);
    chk("t3_go_count", 32'(go_cnt - go_base), 32'd2);

    // 4a: START and STOP together -> nothing happens
    go_base = go_cnt; done_base = done_cnt;
    @(negedge aclk);
    start = 1'b1; stop = 1'b1; continuous = 1'b0; num_frames = 16'd3;
    @(negedge aclk);
    start = 1'b0; stop = 1'b0;
    chk("t4_ss_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge aclk);
    chk("t4_ss_go",   32'(go_cnt - go_base),     32'd0);
    chk("t4_ss_done", 32'(done_cnt - done_base), 32'd0);
    chk("t4_ss_cnt",  32'(frame_cnt),            32'd2);

    // 4b: single mode with zero frames
    pulse_start(1'b0, 16'd0, 16'd4);
    chk("t4_z_done", 32'(done),      32'd1);
    chk("t4_z_busy", 32'(busy),      32'd0);
    chk("t4_z_cnt",  32'(frame_cnt), 32'd0);
    @(negedge aclk);
    chk("t4_z_done_pulse", 32'(done), 32'd0);
    repeat (5) @(negedge aclk);
    chk("t4_z_go", 32'(go_cnt - go_base), 32'd0);

    // 5a: START during WAIT_END is ignored
    go_base = go_cnt;
    pulse_start(1'b0, 16'd2, 16'd2);
    wait_go(go_base + 1, 20, "t5_go1");
    repeat (4) @(negedge aclk);
    pulse_start(1'b0, 16'd5, 16'd2);
    wait_done(100, "t5_done");
    chk("t5_go_count", 32'(go_cnt - go_base), 32'd2);
    chk("t5_cnt",      32'(frame_cnt),        32'd2);
    repeat (40) @(negedge aclk);
    chk("t5_go_after", 32'(go_cnt - go_base), 32'd2);

    // 5b: asynchronous reset in the GO cycle of frame 2
    go_base = go_cnt;
    pulse_start(1'b0, 16'd3, 16'd2);
    wait_go(go_base + 2, 60, "t5r_go2");
    chk("t5r_pre_go",  32'(sender_go), 32'd1);
    chk("t5r_pre_cnt", 32'(frame_cnt), 32'd1);
    #1;
    aresetn = 1'b0;
    #1;
    chk("t5r_go",   32'(sender_go), 32'd0);
    chk("t5r_busy", 32'(busy),      32'd0);
    chk("t5r_cnt",  32'(frame_cnt), 32'd0);
    chk("t5r_done", 32'(done),      32'd0);
    chk("t5r_err",  32'(err),       32'd0);
    repeat (15) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("t5r_busy_after", 32'(busy), 32'd0);

`ifdef SEQ_TIMEOUT_EN
    // 6: sender never raises RUN
    sender_en = 1'b0;
    go_base = go_cnt;
    pulse_start(1'b0, 16'd1, 16'd0);
    wait_done(60, "t6_done");
    chk("t6_err",     32'(err),                         32'd1);
    chk("t6_cnt",     32'(frame_cnt),                   32'd0);
    chk("t6_latency", 32'(last_done_cyc - last_go_cyc), 32'd17);
    chk("t6_go",      32'(go_cnt - go_base),            32'd1);
    repeat (3) @(negedge aclk);
    chk("t6_err_sticky", 32'(err), 32'd1);
    sender_en = 1'b1;
    pulse_start(1'b0, 16'd1, 16'd0);
    chk("t6_err_clr", 32'(err), 32'd0);
    wait_done(60, "t6_done2");
    chk("t6_cnt2", 32'(frame_cnt), 32'd1);
`else
    chk("t6_err_tied", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
